// File: rtl/m_pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : m_pipe_addsub_pkg
// Description : Shared constants and helpers for the pipelined adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`ifndef D_N
`define D_N 32
`endif

package m_pipe_addsub_pkg;

    localparam int c_D_N = `D_N;

    // Full-adder carry: majority of the three inputs.
    function automatic logic f_maj(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

    function automatic bit f_params_ok(input int n, input int s);
        return (s >= 1) && (s <= n) && ((n % s) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_pipe_addsub_add_seg.sv
`default_nettype none
// ============================================================================
// Module      : m_add_seg
// Description : Combinational W-bit ripple adder made of full-adder cells.
//               Also exposes the carry into the MSB for overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module m_add_seg
    import m_pipe_addsub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_ci,
    output logic [W-1:0] o_s,
    output logic         o_co,
    output logic         o_cm
);

    logic [W:0] w_c;

    assign w_c[0] = i_ci;

    genvar i;
    for (i = 0; i < W; i++) begin : g_fa
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = f_maj(i_a[i], i_b[i], w_c[i]);
    end

    assign o_co = w_c[W];
    assign o_cm = w_c[W-1];

endmodule

`default_nettype wire

// File: rtl/m_pipe_addsub.sv
`default_nettype none
// ============================================================================
// Module      : m_pipe_addsub
// Description : P_S-stage pipelined adder/subtractor with valid/ready on both
//               sides; one W-bit segment is added per stage.
// Revision    : 1.0 - initial release
// ============================================================================
module m_pipe_addsub
    import m_pipe_addsub_pkg::*;
#(
    parameter int P_N = c_D_N,
    parameter int P_S = 4
) (
    input  logic           w_clk,
    input  logic           w_rst,
    input  logic           w_in_valid,
    output logic           w_in_ready,
    input  logic [P_N-1:0] w_a,
    input  logic [P_N-1:0] w_b,
    input  logic           w_sub,
    output logic           w_out_valid,
    input  logic           w_out_ready,
    output logic [P_N-1:0] w_s,
    output logic           w_cout,
    output logic           w_ovf
);

    localparam int c_W = P_N / P_S;

    if (!f_params_ok(P_N, P_S)) begin : g_param_check
        $error("m_pipe_addsub: P_N (%0d) must be a multiple of P_S (%0d)", P_N, P_S);
    end

    logic [P_S-1:0] r_vld;
    logic [P_N-1:0] r_a [P_S];
    logic [P_N-1:0] r_b [P_S];
    logic [P_N-1:0] r_s [P_S];
    logic [P_S-1:0] r_c;
    logic           r_ovf;

    logic           w_stall;
    logic [P_S-1:0] w_vin;
    logic [P_S-1:0] w_ci;
    logic [P_N-1:0] w_op_a [P_S];
    logic [P_N-1:0] w_op_b [P_S];
    logic [P_N-1:0] w_acc  [P_S];
    logic [c_W-1:0] w_seg_s  [P_S];
    logic           w_seg_co [P_S];
    logic           w_seg_cm [P_S];

    assign w_stall    = w_out_valid & ~w_out_ready;
    assign w_in_ready = ~w_stall;

    // Operands travel shifted right by one segment per stage, so every stage
    // adds the low W bits of what it receives. Results shift in from the top.
    always_comb begin
        w_vin[0]  = w_in_valid;
        w_op_a[0] = w_a;
        w_op_b[0] = w_sub ? ~w_b : w_b;
        w_ci[0]   = w_sub;
        w_acc[0]  = '0;
        for (int k = 1; k < P_S; k++) begin
            w_vin[k]  = r_vld[k-1];
            w_op_a[k] = r_a[k-1];
            w_op_b[k] = r_b[k-1];
            w_ci[k]   = r_c[k-1];
            w_acc[k]  = r_s[k-1];
        end
    end

    genvar g;
    for (g = 0; g < P_S; g++) begin : g_seg
        m_add_seg #(
            .W (c_W)
        ) u_add_seg (
            .i_a  (w_op_a[g][c_W-1:0]),
            .i_b  (w_op_b[g][c_W-1:0]),
            .i_ci (w_ci[g]),
            .o_s  (w_seg_s[g]),
            .o_co (w_seg_co[g]),
            .o_cm (w_seg_cm[g])
        );
    end

    // A stall freezes every stage, valid bits included; bubbles are not compacted.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < P_S; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_vld <= w_vin;
            r_ovf <= w_seg_co[P_S-1] ^ w_seg_cm[P_S-1];
            for (int k = 0; k < P_S; k++) begin
                r_a[k] <= w_op_a[k] >> c_W;
                r_b[k] <= w_op_b[k] >> c_W;
                r_s[k] <= (w_acc[k] >> c_W) | (P_N'(w_seg_s[k]) << (P_N - c_W));
                r_c[k] <= w_seg_co[k];
            end
        end
    end

    assign w_out_valid = r_vld[P_S-1];
    assign w_s         = r_s[P_S-1];
    assign w_cout      = r_c[P_S-1];
    assign w_ovf       = r_ovf;

endmodule

`default_nettype wire
